// File: rtl/crypto_atm_if.sv
// Command/result bundle between the ATM front-end FSM and the account engine.
// The front-end drives the commands and the engine returns balances and status.
interface crypto_atm_if;
    logic [11:0] accNumber;
    logic [3:0]  pin;
    logic [15:0] current_state;
    logic [1:0]  menuOption;
    logic [2:0]  currency_type_in;
    logic [2:0]  currency_type_2_in;
    logic [10:0] amount;
    logic        ready;
    logic [11:0] destinationAcc;
    logic [15:0] balance_dollars_out;
    logic [15:0] balance_btc_out;
    logic [15:0] balance_eth_out;
    logic [15:0] balance_xrp_out;
    logic [15:0] balance_ltc_out;
    logic [3:0]  status_code;

    modport master (
        output accNumber, pin, current_state, menuOption, currency_type_in,
               currency_type_2_in, amount, ready, destinationAcc,
        input  balance_dollars_out, balance_btc_out, balance_eth_out,
               balance_xrp_out, balance_ltc_out, status_code
    );

    modport slave (
        input  accNumber, pin, current_state, menuOption, currency_type_in,
               currency_type_2_in, amount, ready, destinationAcc,
        output balance_dollars_out, balance_btc_out, balance_eth_out,
               balance_xrp_out, balance_ltc_out, status_code
    );
endinterface

// File: rtl/crypto_atm.sv
// Account and wallet engine: fixed account table, five balances per account,
// one command executed per rising edge of ready, selected by the one-hot UI state.
module crypto_atm #(
    parameter int NUM_ACC  = 4,
    parameter int RATE_BTC = 200,
    parameter int RATE_ETH = 50,
    parameter int RATE_XRP = 1,
    parameter int RATE_LTC = 20
) (
    input  logic         clk,
    input  logic         rst,
    crypto_atm_if.slave  bus
);
    localparam logic [15:0] S_IDLE = 16'h0001, S_ACC = 16'h0002, S_PIN = 16'h0004,
                            S_CONV1 = 16'h0040, S_CONV2 = 16'h0080, S_WDAMT = 16'h0200,
                            S_XFER = 16'h0400, S_XCUR = 16'h0800, S_XAMT = 16'h1000;
    localparam logic [3:0] ST_NONE = 4'd0, ST_FOUND = 4'd1, ST_LOGIN = 4'd2, ST_SEL = 4'd3,
                           ST_OK = 4'd4, ST_DEST = 4'd5, ST_UNK = 4'd8, ST_PIN = 4'd9,
                           ST_FUNDS = 4'd10, ST_INV = 4'd11, ST_OVF = 4'd12;

    function automatic logic [31:0] rate(input logic [2:0] c);
        case (c)
            3'd1:    rate = 32'(RATE_BTC);
            3'd2:    rate = 32'(RATE_ETH);
            3'd3:    rate = 32'(RATE_XRP);
            3'd4:    rate = 32'(RATE_LTC);
            default: rate = 32'd1;
        endcase
    endfunction

    function automatic logic [15:0] init_bal(input int c);
        case (c)
            0:       init_bal = 16'd1000;
            1:       init_bal = 16'd10;
            2:       init_bal = 16'd20;
            3:       init_bal = 16'd500;
            default: init_bal = 16'd50;
        endcase
    endfunction

    // Returns {hit, index}; PIN of each account equals its index.
    function automatic logic [2:0] lookup(input logic [11:0] a);
        case (a)
            12'd2749: lookup = 3'b100;
            12'd2175: lookup = 3'b101;
            12'd1234: lookup = 3'b110;
            12'd3412: lookup = 3'b111;
            default:  lookup = 3'b000;
        endcase
    endfunction

    logic [15:0] r_bal     [NUM_ACC][5];
    logic [15:0] w_bal_nxt [NUM_ACC][5];
    logic [15:0] r_out [5];
    logic        r_ready, r_logged, r_acc_valid, r_dest_valid;
    logic [1:0]  r_idx, r_dest;
    logic [3:0]  r_status;
    logic        w_logged_nxt, w_acc_valid_nxt, w_dest_valid_nxt;
    logic [1:0]  w_idx_nxt, w_dest_nxt;
    logic [3:0]  w_status_nxt;

    logic        w_fire, w_src_ok, w_dst_ok, w_unused;
    logic [2:0]  w_src, w_dst, w_acc_lu, w_dst_lu;
    logic [15:0] w_amt, w_src_bal, w_dst_bal, w_tgt_bal;
    logic [31:0] w_usd, w_credit;
    logic [32:0] w_conv_sum;
    logic [16:0] w_xfer_sum;

    assign w_unused   = ^bus.menuOption;
    assign w_fire     = bus.ready & ~r_ready;
    assign w_src      = bus.currency_type_in;
    assign w_dst      = bus.currency_type_2_in;
    assign w_src_ok   = (w_src <= 3'd4);
    assign w_dst_ok   = (w_dst <= 3'd4);
    assign w_amt      = {5'b0, bus.amount};
    assign w_acc_lu   = lookup(bus.accNumber);
    assign w_dst_lu   = lookup(bus.destinationAcc);
    assign w_src_bal  = w_src_ok ? r_bal[r_idx][w_src]  : 16'd0;
    assign w_dst_bal  = w_dst_ok ? r_bal[r_idx][w_dst]  : 16'd0;
    assign w_tgt_bal  = w_src_ok ? r_bal[r_dest][w_src] : 16'd0;
    assign w_usd      = {21'b0, bus.amount} * rate(w_src);
    assign w_credit   = w_usd / rate(w_dst);
    assign w_conv_sum = {17'b0, w_dst_bal} + {1'b0, w_credit};
    assign w_xfer_sum = {1'b0, w_tgt_bal} + {1'b0, w_amt};

    always_comb begin
        w_bal_nxt        = r_bal;
        w_logged_nxt     = r_logged;
        w_acc_valid_nxt  = r_acc_valid;
        w_dest_valid_nxt = r_dest_valid;
        w_idx_nxt        = r_idx;
        w_dest_nxt       = r_dest;
        w_status_nxt     = r_status;
        if (bus.current_state == S_IDLE) begin
            w_logged_nxt     = 1'b0;
            w_acc_valid_nxt  = 1'b0;
            w_dest_valid_nxt = 1'b0;
            w_status_nxt     = ST_NONE;
        end else if (w_fire) begin
            case (bus.current_state)
                S_ACC: begin
                    w_logged_nxt    = 1'b0;
                    w_acc_valid_nxt = w_acc_lu[2];
                    w_status_nxt    = w_acc_lu[2] ? ST_FOUND : ST_UNK;
                    if (w_acc_lu[2]) w_idx_nxt = w_acc_lu[1:0];
                end
                S_PIN: begin
                    w_logged_nxt = r_acc_valid && (bus.pin == {2'b0, r_idx});
                    w_status_nxt = w_logged_nxt ? ST_LOGIN : ST_PIN;
                end
                S_CONV1, S_XCUR: w_status_nxt = r_logged ? ST_SEL : ST_INV;
                S_CONV2: begin
                    if (!r_logged || !w_src_ok || !w_dst_ok || w_src == w_dst)
                        w_status_nxt = ST_INV;
                    else if (w_src_bal < w_amt)
                        w_status_nxt = ST_FUNDS;
                    else if (|w_conv_sum[32:16])
                        w_status_nxt = ST_OVF;
                    else begin
                        w_bal_nxt[r_idx][w_src] = w_src_bal - w_amt;
                        w_bal_nxt[r_idx][w_dst] = w_conv_sum[15:0];
                        w_status_nxt = ST_OK;
                    end
                end
                S_WDAMT: begin
                    if (!r_logged || !w_src_ok) w_status_nxt = ST_INV;
                    else if (w_src_bal < w_amt) w_status_nxt = ST_FUNDS;
                    else begin
                        w_bal_nxt[r_idx][w_src] = w_src_bal - w_amt;
                        w_status_nxt = ST_OK;
                    end
                end
                S_XFER: begin
                    if (!r_logged) w_status_nxt = ST_INV;
                    else if (w_dst_lu[2] && w_dst_lu[1:0] != r_idx) begin
                        w_dest_nxt       = w_dst_lu[1:0];
                        w_dest_valid_nxt = 1'b1;
                        w_status_nxt     = ST_DEST;
                    end else begin
                        w_dest_valid_nxt = 1'b0;
                        w_status_nxt     = w_dst_lu[2] ? ST_INV : ST_UNK;
                    end
                end
                S_XAMT: begin
                    // A stale destination equal to the current account would mint funds.
                    if (!r_logged || !r_dest_valid || !w_src_ok || r_dest == r_idx)
                        w_status_nxt = ST_INV;
                    else if (w_src_bal < w_amt) w_status_nxt = ST_FUNDS;
                    else if (w_xfer_sum[16]) w_status_nxt = ST_OVF;
                    else begin
                        w_bal_nxt[r_idx][w_src]  = w_src_bal - w_amt;
                        w_bal_nxt[r_dest][w_src] = w_xfer_sum[15:0];
                        w_status_nxt = ST_OK;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < NUM_ACC; a++)
                for (int c = 0; c < 5; c++) r_bal[a][c] <= init_bal(c);
            for (int c = 0; c < 5; c++) r_out[c] <= 16'd0;
            r_ready      <= 1'b0;
            r_logged     <= 1'b0;
            r_acc_valid  <= 1'b0;
            r_dest_valid <= 1'b0;
            r_idx        <= 2'd0;
            r_dest       <= 2'd0;
            r_status     <= ST_NONE;
        end else begin
            r_bal        <= w_bal_nxt;
            r_ready      <= bus.ready;
            r_logged     <= w_logged_nxt;
            r_acc_valid  <= w_acc_valid_nxt;
            r_dest_valid <= w_dest_valid_nxt;
            r_idx        <= w_idx_nxt;
            r_dest       <= w_dest_nxt;
            r_status     <= w_status_nxt;
            for (int c = 0; c < 5; c++)
                r_out[c] <= w_logged_nxt ? w_bal_nxt[w_idx_nxt][c] : 16'd0;
        end
    end

    assign bus.balance_dollars_out = r_out[0];
    assign bus.balance_btc_out     = r_out[1];
    assign bus.balance_eth_out     = r_out[2];
    assign bus.balance_xrp_out     = r_out[3];
    assign bus.balance_ltc_out     = r_out[4];
    assign bus.status_code         = r_status;
endmodule

// File: tb/tb_crypto_atm.sv
// Directed bench for crypto_atm: login, convert, withdraw, transfer, relogin,
// edge-strobe behaviour and asynchronous reset.
module tb_crypto_atm;
    localparam logic [15:0] S_IDLE = 16'h0001, S_ACC = 16'h0002, S_PIN = 16'h0004,
                            S_MENU = 16'h0008, S_CONV1 = 16'h0040, S_CONV2 = 16'h0080,
                            S_WDAMT = 16'h0200, S_XFER = 16'h0400, S_XAMT = 16'h1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    crypto_atm_if bus();

    crypto_atm dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [15:0] st);
        @(negedge clk);
        bus.current_state = st;
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
    endtask

    task automatic login(input logic [11:0] acc, input logic [3:0] p);
        bus.accNumber = acc;
        pulse(S_ACC);
        bus.pin = p;
        pulse(S_PIN);
    endtask

    task automatic chk_bal(input string tag, input logic [15:0] u, input logic [15:0] b,
                           input logic [15:0] e, input logic [15:0] x, input logic [15:0] l);
        chk({tag, "_usd"}, bus.balance_dollars_out, u);
        chk({tag, "_btc"}, bus.balance_btc_out, b);
        chk({tag, "_eth"}, bus.balance_eth_out, e);
        chk({tag, "_xrp"}, bus.balance_xrp_out, x);
        chk({tag, "_ltc"}, bus.balance_ltc_out, l);
    endtask

    initial begin
        bus.accNumber = '0; bus.pin = '0; bus.current_state = S_MENU; bus.menuOption = '0;
        bus.currency_type_in = '0; bus.currency_type_2_in = '0; bus.amount = '0;
        bus.ready = 1'b0; bus.destinationAcc = '0;
        repeat (2) @(negedge clk);
        chk("reset_status", {12'b0, bus.status_code}, 16'd0);
        chk_bal("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        bus.accNumber = 12'd2749;
        pulse(S_ACC);
        chk("acc_found", {12'b0, bus.status_code}, 16'd1);
        chk("acc_found_usd", bus.balance_dollars_out, 16'd0);
        bus.pin = 4'd0;
        pulse(S_PIN);
        chk("login_ok", {12'b0, bus.status_code}, 16'd2);
        chk_bal("login", 1000, 10, 20, 500, 50);

        // ETH -> USD, 1 ETH = 50 USD
        bus.currency_type_in = 3'd2; bus.currency_type_2_in = 3'd0; bus.amount = 11'd1;
        pulse(S_CONV2);
        chk("conv_status", {12'b0, bus.status_code}, 16'd4);
        chk_bal("conv", 1050, 10, 19, 500, 50);
        bus.currency_type_in = 3'd1; bus.currency_type_2_in = 3'd1;
        pulse(S_CONV2);
        chk("conv_same", {12'b0, bus.status_code}, 16'd11);
        chk("conv_same_btc", bus.balance_btc_out, 16'd10);
        bus.currency_type_in = 3'd5; bus.currency_type_2_in = 3'd0;
        pulse(S_CONV2);
        chk("conv_badsrc", {12'b0, bus.status_code}, 16'd11);
        pulse(S_CONV1);
        chk("sel_conv1", {12'b0, bus.status_code}, 16'd3);

        bus.currency_type_in = 3'd0; bus.amount = 11'd100;
        pulse(S_WDAMT);
        chk("wd_status", {12'b0, bus.status_code}, 16'd4);
        chk("wd_usd", bus.balance_dollars_out, 16'd950);
        bus.amount = 11'd2000;
        pulse(S_WDAMT);
        chk("wd_funds", {12'b0, bus.status_code}, 16'd10);
        chk("wd_funds_usd", bus.balance_dollars_out, 16'd950);
        bus.amount = 11'd0;
        pulse(S_WDAMT);
        chk("wd_zero", {12'b0, bus.status_code}, 16'd4);
        chk("wd_zero_usd", bus.balance_dollars_out, 16'd950);

        // 10 BTC -> XRP: 2000 USD -> 2000 XRP, BTC drained to zero
        bus.currency_type_in = 3'd1; bus.currency_type_2_in = 3'd3; bus.amount = 11'd10;
        pulse(S_CONV2);
        chk("conv_all_btc", {12'b0, bus.status_code}, 16'd4);
        chk_bal("conv2", 950, 0, 19, 2500, 50);
        bus.amount = 11'd1;
        pulse(S_WDAMT);
        chk("wd_empty_btc", {12'b0, bus.status_code}, 16'd10);

        bus.destinationAcc = 12'd2749;
        pulse(S_XFER);
        chk("xfer_self", {12'b0, bus.status_code}, 16'd11);
        bus.destinationAcc = 12'd999;
        pulse(S_XFER);
        chk("xfer_unknown", {12'b0, bus.status_code}, 16'd8);
        bus.currency_type_in = 3'd0; bus.amount = 11'd100;
        pulse(S_XAMT);
        chk("xfer_nodest", {12'b0, bus.status_code}, 16'd11);
        bus.destinationAcc = 12'd2175;
        pulse(S_XFER);
        chk("xfer_dest", {12'b0, bus.status_code}, 16'd5);
        pulse(S_XAMT);
        chk("xfer_status", {12'b0, bus.status_code}, 16'd4);
        chk("xfer_usd", bus.balance_dollars_out, 16'd850);
        pulse(S_MENU);
        chk("menu_hold", {12'b0, bus.status_code}, 16'd4);

        @(negedge clk);
        bus.current_state = S_IDLE;
        @(negedge clk);
        chk("idle_status", {12'b0, bus.status_code}, 16'd0);
        chk_bal("idle", 0, 0, 0, 0, 0);

        login(12'd2175, 4'd1);
        chk("relogin", {12'b0, bus.status_code}, 16'd2);
        chk_bal("relogin", 1100, 10, 20, 500, 50);
        login(12'd2175, 4'd3);
        chk("bad_pin", {12'b0, bus.status_code}, 16'd9);
        chk("bad_pin_usd", bus.balance_dollars_out, 16'd0);
        bus.currency_type_in = 3'd0; bus.amount = 11'd5;
        pulse(S_WDAMT);
        chk("wd_logged_out", {12'b0, bus.status_code}, 16'd11);
        bus.accNumber = 12'd999;
        pulse(S_ACC);
        chk("acc_unknown", {12'b0, bus.status_code}, 16'd8);

        // ready held high for several cycles: withdraw must happen once
        login(12'd2175, 4'd1);
        bus.currency_type_in = 3'd0; bus.amount = 11'd10;
        @(negedge clk);
        bus.current_state = S_WDAMT;
        bus.ready = 1'b1;
        repeat (6) @(negedge clk);
        bus.ready = 1'b0;
        chk("hold_once_usd", bus.balance_dollars_out, 16'd1090);
        chk("hold_once_status", {12'b0, bus.status_code}, 16'd4);

        #2 rst = 1'b1;
        #1;
        chk("async_rst_status", {12'b0, bus.status_code}, 16'd0);
        chk("async_rst_usd", bus.balance_dollars_out, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        login(12'd2175, 4'd1);
        chk_bal("rst_2175", 1000, 10, 20, 500, 50);
        login(12'd2749, 4'd0);
        chk_bal("rst_2749", 1000, 10, 20, 500, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/crypto_atm.md
Name: crypto_atm

Overview:
Account and wallet engine of the crypto ATM. It holds a small fixed account table with PINs and five per-account balances (USD, BTC, ETH, XRP, LTC). It executes one command per rising edge of `ready`; the command is selected by the one-hot UI state that the front-end FSM drives on `current_state`. It reports the logged-in account's balances and a status code.

Parameters:
NUM_ACC, 4, number of accounts in the table
RATE_BTC, 200, USD value of 1 BTC
RATE_ETH, 50, USD value of 1 ETH
RATE_XRP, 1, USD value of 1 XRP
RATE_LTC, 20, USD value of 1 LTC (USD rate is fixed at 1)

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  asynchronous active-high reset
accNumber  in  12  account number to log in
pin  in  4  PIN for the latched account
current_state  in  16  one-hot UI state: IDLE=bit0, ACC_NUM=bit1, PIN_INPUT=bit2, MENU=bit3, SHOW_BALANCES=bit4, CONVERT_CURRENCY=bit5, SELECT_CURRENCY_CONVERT_1=bit6, SELECT_CURRENCY_CONVERT_2=bit7, WITHDRAW=bit8, SELECT_AMOUNT_WITHDRAW=bit9, TRANSFER=bit10, SELECT_CURRENCY_TRANSFER=bit11, SELECT_AMOUNT_TRANSFER=bit12, ERROR=bit13, SUCCESS=bit14
menuOption  in  2  menu selection; informational only, no internal effect
currency_type_in  in  3  source currency: USD=0, BTC=1, ETH=2, XRP=3, LTC=4
currency_type_2_in  in  3  destination currency for conversion, same encoding
amount  in  11  unsigned amount in source-currency units
ready  in  1  command strobe; acted on at its rising edge
destinationAcc  in  12  transfer target account number
balance_dollars_out / balance_btc_out / balance_eth_out / balance_xrp_out / balance_ltc_out  out  16 each  balances of the logged-in account; 0 when not logged in
status_code  out  4  result of the last command

Behaviour:
- Account table (constant): idx0 = 2749 / PIN 0; idx1 = 2175 / PIN 1; idx2 = 1234 / PIN 2; idx3 = 3412 / PIN 3.
- Reset: every account's balances go to USD 1000, BTC 10, ETH 20, XRP 500, LTC 50. `acc_valid`, `logged_in`, `dest_valid` and the registered `ready` all clear. `status_code` = 0. All balance outputs = 0.
- Status codes: 0 none/logged out; 1 account found; 2 login OK; 3 selection OK; 4 transaction OK; 8 unknown account; 9 bad PIN; 10 insufficient funds; 11 invalid request; 12 overflow.
- A command fires in the cycle where `ready` = 1 and the registered `ready` = 0. It fires exactly once per pulse.
- Results are registered. Balances and `status_code` update at the same clock edge that sees the edge, i.e. 1-cycle latency.
- IDLE is level-sensitive and needs no `ready`: every cycle it clears `logged_in`, `acc_valid` and `dest_valid` and sets status 0.
- ACC_NUM: look up `accNumber`.
  - Hit: latch the index, set `acc_valid`, clear `logged_in`, status 1.
  - Miss: clear `acc_valid` and `logged_in`, status 8.
- PIN_INPUT: if `acc_valid` and `pin` matches the latched account, set `logged_in`, status 2. Otherwise clear `logged_in`, status 9.
- Rule for all remaining commands: if not logged in, status 11 and no change.
- SELECT_CURRENCY_CONVERT_1 and SELECT_CURRENCY_TRANSFER: status 3, no balance change.
- SELECT_CURRENCY_CONVERT_2 (conversion):
  - Invalid (status 11): src or dst > 4, or src == dst.
  - Insufficient (status 10): bal[src] < amount.
  - Otherwise compute usd = amount × rate[src] (32-bit) and credit = usd / rate[dst] (floor).
  - If bal[dst] + credit > 65535, status 12.
  - Otherwise bal[src] -= amount, bal[dst] += credit, status 4.
- SELECT_AMOUNT_WITHDRAW: src > 4 gives status 11; bal[src] < amount gives status 10; otherwise bal[src] -= amount, status 4.
- TRANSFER: look up `destinationAcc`.
  - Hit and different from the logged-in index: latch destination, set `dest_valid`, status 5.
  - Miss or self: clear `dest_valid`, status 8 (miss) or 11 (self).
- SELECT_AMOUNT_TRANSFER:
  - Status 11: `dest_valid` clear or src > 4.
  - Status 10: bal[src] < amount.
  - Status 12: destination bal[src] + amount > 65535.
  - Otherwise debit source, credit destination in the same currency, status 4.
- MENU, SHOW_BALANCES, CONVERT_CURRENCY, WITHDRAW, ERROR, SUCCESS, and any non-one-hot value: no action, status held.
- Balance outputs are registered copies of the logged-in account's balances and reflect updates one cycle after the command edge.
- Amount 0 is legal and leaves balances unchanged, with status 4.
- Reset asserted mid-operation restores all initial balances immediately.

Test Plan:
- Login: `accNumber` 2749 + `ready` in ACC_NUM -> status 1. PIN 0 + `ready` in PIN_INPUT -> status 2. Outputs 1000/10/20/500/50.
- Convert: ETH→USD, amount 1 in SELECT_CURRENCY_CONVERT_2 -> ETH 19, USD 1050, status 4. Then BTC→BTC -> status 11.
- Withdraw: USD 100 -> USD 950, status 4. Then USD 2000 -> status 10, USD stays 950.
- Transfer: `destinationAcc` 2175 in TRANSFER -> status 5. USD 100 in SELECT_AMOUNT_TRANSFER -> USD 850, status 4.
- Relogin: IDLE -> outputs 0, status 0. Log in as 2175 with PIN 1 -> USD 1100, others at initial values. Log in as 2175 with PIN 3 -> status 9, outputs 0.
- Unknown account 999 in ACC_NUM -> status 8. Holding `ready` high for many cycles fires exactly one command. Reset mid-sequence restores all balances.
